j2a_burst_engine: RTL and testbench

J2A_BURST_ENGINE -- requirements
Module: j2a_burst_engine

---
 rtl/j2a_burst_engine.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_j2a_burst_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j2a_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : j2a_burst_engine
// Purpose  : Single-command AXI4 INCR burst master with streaming data ports
// Revision : 1.0 - initial release
// ============================================================================
module j2a_burst_engine #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6,
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                    cmd_len,
    input  logic                          wdat_valid,
    output logic                          wdat_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     wdat_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wdat_strb,
    output logic                          rdat_valid,
    input  logic                          rdat_ready,
    output logic [AXI_DATA_WIDTH-1:0]     rdat_data,
    output logic                          rdat_last,
    output logic [1:0]                    rdat_resp,
    output logic                          sts_valid,
    output logic [1:0]                    sts_resp,
    output logic                          sts_timeout,
    output logic                          sts_badcmd,
    output logic [AXI_ID_WIDTH-1:0]       axi_master_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_master_aw_addr,
    output logic [7:0]                    axi_master_aw_len,
    output logic [2:0]                    axi_master_aw_size,
    output logic [1:0]                    axi_master_aw_burst,
    output logic                          axi_master_aw_lock,
    output logic [3:0]                    axi_master_aw_cache,
    output logic [2:0]                    axi_master_aw_prot,
    output logic [3:0]                    axi_master_aw_qos,
    output logic [3:0]                    axi_master_aw_region,
    output logic [AXI_USER_WIDTH-1:0]     axi_master_aw_user,
    output logic                          axi_master_aw_valid,
    input  logic                          axi_master_aw_ready,
    output logic [AXI_DATA_WIDTH-1:0]     axi_master_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   axi_master_w_strb,
    output logic                          axi_master_w_last,
    output logic [AXI_USER_WIDTH-1:0]     axi_master_w_user,
    output logic                          axi_master_w_valid,
    input  logic                          axi_master_w_ready,
    input  logic [1:0]                    axi_master_b_resp,
    input  logic                          axi_master_b_valid,
    output logic                          axi_master_b_ready,
    output logic [AXI_ID_WIDTH-1:0]       axi_master_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_master_ar_addr,
    output logic [7:0]                    axi_master_ar_len,
    output logic [2:0]                    axi_master_ar_size,
    output logic [1:0]                    axi_master_ar_burst,
    output logic                          axi_master_ar_lock,
    output logic [3:0]                    axi_master_ar_cache,
    output logic [2:0]                    axi_master_ar_prot,
    output logic [3:0]                    axi_master_ar_qos,
    output logic [3:0]                    axi_master_ar_region,
    output logic [AXI_USER_WIDTH-1:0]     axi_master_ar_user,
    output logic                          axi_master_ar_valid,
    input  logic                          axi_master_ar_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_master_r_data,
    input  logic [1:0]                    axi_master_r_resp,
    input  logic                          axi_master_r_last,
    input  logic                          axi_master_r_valid,
    output logic                          axi_master_r_ready
);
    localparam int c_BYTES = AXI_DATA_WIDTH / 8;
    localparam int c_SIZE  = $clog2(c_BYTES);
    localparam int c_WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;
    localparam logic [1:0] c_INCR   = 2'b01;

    typedef enum logic [2:0] {
        IDLE, CHECK, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
    } state_t;

    state_t                      state_q, state_d;
    logic                        write_q, write_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                  len_q, len_d, beat_q, beat_d;
    logic [1:0]                  resp_q, resp_d, sts_resp_q, sts_resp_d;
    logic                        ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d;
    logic                        sts_timeout_q, sts_timeout_d, sts_badcmd_q, sts_badcmd_d;
    logic [c_WD_W-1:0]           wdog_q, wdog_d;

    logic        w_rd, w_wd, w_cmd_hs, w_r_hs, w_w_hs, w_b_hs, w_bad;
    logic [13:0] w_span_end;
    logic [1:0]  w_resp_in, w_resp_acc;

    assign w_rd      = (state_q == RD_DATA);
    assign w_wd      = (state_q == WR_DATA);
    assign cmd_ready = (state_q == IDLE) && !axi_areset;
    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_r_hs    = w_rd && axi_master_r_valid && rdat_ready;
    assign w_w_hs    = w_wd && wdat_valid && axi_master_w_ready;
    assign w_b_hs    = (state_q == WR_RESP) && axi_master_b_valid;

    // End offset of the burst within its 4 KB page; exactly 4096 still fits.
    assign w_span_end = {2'b00, addr_q[11:0]} + (({6'd0, len_q} + 14'd1) << c_SIZE);
    assign w_bad      = ({1'b0, len_q} >= 9'(MAX_LEN)) || (addr_q[c_SIZE-1:0] != '0)
                        || (w_span_end > 14'd4096);

    assign w_resp_in  = w_rd ? axi_master_r_resp : axi_master_b_resp;
    assign w_resp_acc = (resp_q != c_OKAY) ? resp_q : w_resp_in;

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        resp_d        = resp_q;
        ar_valid_d    = ar_valid_q;
        aw_valid_d    = aw_valid_q;
        sts_resp_d    = sts_resp_q;
        sts_timeout_d = sts_timeout_q;
        sts_badcmd_d  = sts_badcmd_q;
        wdog_d        = '0;
        case (state_q)
            IDLE: begin
                if (w_cmd_hs) begin
                    state_d       = CHECK;
                    write_d       = cmd_write;
                    addr_d        = cmd_addr;
                    len_d         = cmd_len;
                    beat_d        = '0;
                    resp_d        = c_OKAY;
                    sts_resp_d    = c_OKAY;
                    sts_timeout_d = 1'b0;
                    sts_badcmd_d  = 1'b0;
                end
            end
            CHECK: begin
                if (w_bad) begin
                    state_d      = DONE;
                    sts_badcmd_d = 1'b1;
                    sts_resp_d   = c_SLVERR;
                end else if (write_q) begin
                    state_d    = WR_ADDR;
                    aw_valid_d = 1'b1;
                end else begin
                    state_d    = RD_ADDR;
                    ar_valid_d = 1'b1;
                end
            end
            RD_ADDR: begin
                if (axi_master_ar_ready) begin
                    state_d    = RD_DATA;
                    ar_valid_d = 1'b0;
                end
            end
            RD_DATA: begin
                if (w_r_hs) begin
                    resp_d = w_resp_acc;
                    if (axi_master_r_last) begin
                        state_d    = DONE;
                        sts_resp_d = w_resp_acc;
                    end
                end else if (wdog_q == c_WD_LAST) begin
                    state_d       = DONE;
                    sts_timeout_d = 1'b1;
                    sts_resp_d    = c_SLVERR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            WR_ADDR: begin
                if (axi_master_aw_ready) begin
                    state_d    = WR_DATA;
                    aw_valid_d = 1'b0;
                end
            end
            WR_DATA: begin
                if (w_w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == len_q) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (w_b_hs) begin
                    state_d    = DONE;
                    resp_d     = w_resp_acc;
                    sts_resp_d = w_resp_acc;
                end else if (wdog_q == c_WD_LAST) begin
                    state_d       = DONE;
                    sts_timeout_d = 1'b1;
                    sts_resp_d    = c_SLVERR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            resp_q        <= c_OKAY;
            ar_valid_q    <= 1'b0;
            aw_valid_q    <= 1'b0;
            sts_resp_q    <= c_OKAY;
            sts_timeout_q <= 1'b0;
            sts_badcmd_q  <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            resp_q        <= resp_d;
            ar_valid_q    <= ar_valid_d;
            aw_valid_q    <= aw_valid_d;
            sts_resp_q    <= sts_resp_d;
            sts_timeout_q <= sts_timeout_d;
            sts_badcmd_q  <= sts_badcmd_d;
            wdog_q        <= wdog_d;
        end
    end

    assign rdat_valid         = w_rd ? axi_master_r_valid : 1'b0;
    assign axi_master_r_ready = w_rd ? rdat_ready : 1'b0;
    assign rdat_data          = w_rd ? axi_master_r_data : '0;
    assign rdat_resp          = w_rd ? axi_master_r_resp : 2'b00;
    assign rdat_last          = w_rd ? axi_master_r_last : 1'b0;

    assign axi_master_w_valid = w_wd ? wdat_valid : 1'b0;
    assign wdat_ready         = w_wd ? axi_master_w_ready : 1'b0;
    assign axi_master_w_data  = w_wd ? wdat_data : '0;
    assign axi_master_w_strb  = w_wd ? wdat_strb : '0;
    assign axi_master_w_last  = w_wd && (beat_q == len_q);
    assign axi_master_w_user  = '0;
    assign axi_master_b_ready = (state_q == WR_RESP);

    assign axi_master_aw_valid  = aw_valid_q;
    assign axi_master_aw_addr   = addr_q;
    assign axi_master_aw_len    = len_q;
    assign axi_master_aw_size   = aw_valid_q ? 3'(c_SIZE) : 3'd0;
    assign axi_master_aw_burst  = aw_valid_q ? c_INCR : 2'b00;
    assign axi_master_aw_id     = '0;
    assign axi_master_aw_lock   = 1'b0;
    assign axi_master_aw_cache  = '0;
    assign axi_master_aw_prot   = '0;
    assign axi_master_aw_qos    = '0;
    assign axi_master_aw_region = '0;
    assign axi_master_aw_user   = '0;

    assign axi_master_ar_valid  = ar_valid_q;
    assign axi_master_ar_addr   = addr_q;
    assign axi_master_ar_len    = len_q;
    assign axi_master_ar_size   = ar_valid_q ? 3'(c_SIZE) : 3'd0;
    assign axi_master_ar_burst  = ar_valid_q ? c_INCR : 2'b00;
    assign axi_master_ar_id     = '0;
    assign axi_master_ar_lock   = 1'b0;
    assign axi_master_ar_cache  = '0;
    assign axi_master_ar_prot   = '0;
    assign axi_master_ar_qos    = '0;
    assign axi_master_ar_region = '0;
    assign axi_master_ar_user   = '0;

    assign sts_valid   = (state_q == DONE);
    assign sts_resp    = sts_resp_q;
    assign sts_timeout = sts_timeout_q;
    assign sts_badcmd  = sts_badcmd_q;
endmodule
`default_nettype wire

// File: tb/tb_j2a_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_j2a_burst_engine
// Purpose  : Self-checking bench for j2a_burst_engine with reactive AXI slave
// Revision : 1.0 - initial release
// ============================================================================
module tb_j2a_burst_engine;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int ML = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic wdat_valid, wdat_ready;
    logic [DW-1:0] wdat_data;
    logic [SW-1:0] wdat_strb;
    logic rdat_valid, rdat_ready, rdat_last;
    logic [DW-1:0] rdat_data;
    logic [1:0] rdat_resp;
    logic sts_valid, sts_timeout, sts_badcmd;
    logic [1:0] sts_resp;
    logic [2:0] aw_id, ar_id, aw_size, ar_size, aw_prot, ar_prot;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0] aw_len, ar_len;
    logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
    logic aw_lock, ar_lock, aw_valid, aw_ready, ar_valid, ar_ready;
    logic [3:0] aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic [5:0] aw_user, ar_user, w_user;
    logic [DW-1:0] w_data, r_data;
    logic [SW-1:0] w_strb;
    logic w_last, w_valid, w_ready, b_valid, b_ready, r_last, r_valid, r_ready;

    j2a_burst_engine #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(3),
        .AXI_USER_WIDTH(6), .MAX_LEN(ML), .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_aclk(clk), .axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data), .wdat_strb(wdat_strb),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data),
        .rdat_last(rdat_last), .rdat_resp(rdat_resp),
        .sts_valid(sts_valid), .sts_resp(sts_resp), .sts_timeout(sts_timeout), .sts_badcmd(sts_badcmd),
        .axi_master_aw_id(aw_id), .axi_master_aw_addr(aw_addr), .axi_master_aw_len(aw_len),
        .axi_master_aw_size(aw_size), .axi_master_aw_burst(aw_burst), .axi_master_aw_lock(aw_lock),
        .axi_master_aw_cache(aw_cache), .axi_master_aw_prot(aw_prot), .axi_master_aw_qos(aw_qos),
        .axi_master_aw_region(aw_region), .axi_master_aw_user(aw_user),
        .axi_master_aw_valid(aw_valid), .axi_master_aw_ready(aw_ready),
        .axi_master_w_data(w_data), .axi_master_w_strb(w_strb), .axi_master_w_last(w_last),
        .axi_master_w_user(w_user), .axi_master_w_valid(w_valid), .axi_master_w_ready(w_ready),
        .axi_master_b_resp(b_resp), .axi_master_b_valid(b_valid), .axi_master_b_ready(b_ready),
        .axi_master_ar_id(ar_id), .axi_master_ar_addr(ar_addr), .axi_master_ar_len(ar_len),
        .axi_master_ar_size(ar_size), .axi_master_ar_burst(ar_burst), .axi_master_ar_lock(ar_lock),
        .axi_master_ar_cache(ar_cache), .axi_master_ar_prot(ar_prot), .axi_master_ar_qos(ar_qos),
        .axi_master_ar_region(ar_region), .axi_master_ar_user(ar_user),
        .axi_master_ar_valid(ar_valid), .axi_master_ar_ready(ar_ready),
        .axi_master_r_data(r_data), .axi_master_r_resp(r_resp), .axi_master_r_last(r_last),
        .axi_master_r_valid(r_valid), .axi_master_r_ready(r_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] rq_data[$];
    logic [1:0]    rq_resp[$];
    logic [DW-1:0] wq_data[$];
    logic [SW-1:0] wq_strb[$];
    logic [DW-1:0] ew_data[$];
    logic [SW-1:0] ew_strb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Legality of a command from the addressing rules alone.
    function automatic bit exp_bad(input logic [31:0] a, input int len);
        return (len >= ML) || ((a % SW) != 0) || (int'(a % 4096) + (len + 1) * SW > 4096);
    endfunction

    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdat_valid = 1'b0; wdat_data = '0; wdat_strb = '0; rdat_ready = 1'b0;
        aw_ready = 1'b0; ar_ready = 1'b0; w_ready = 1'b0;
        b_valid = 1'b0; b_resp = 2'b00;
        r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
    endtask

    task automatic chk_quiet(input string tag, input logic exp_ready);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(exp_ready));
        chk({tag, "_valids"}, 64'({ar_valid, aw_valid, w_valid, wdat_ready, rdat_valid,
                                   r_ready, b_ready, sts_valid}), 64'd0);
        chk({tag, "_sts"}, 64'({sts_resp, sts_timeout, sts_badcmd}), 64'd0);
        chk({tag, "_addr"}, {ar_addr, aw_addr}, 64'd0);
        chk({tag, "_data"}, {w_data, rdat_data}, 64'd0);
    endtask

    task automatic gen_beats(input int len, input bit all_okay);
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [1:0]    r;
        rq_data.delete(); rq_resp.delete(); wq_data.delete(); wq_strb.delete();
        ew_data.delete(); ew_strb.delete();
        for (int i = 0; i <= len; i++) begin
            d = $urandom;
            s = SW'($urandom);
            r = (all_okay || $urandom_range(0, 5) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
            rq_data.push_back(d); rq_resp.push_back(r);
            wq_data.push_back(d); wq_strb.push_back(s);
            ew_data.push_back(d); ew_strb.push_back(s);
        end
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input int len, input int ar_dly,
                           input bit r_silent, input logic [1:0] bresp, input int abort_at);
        bit bad;
        logic [1:0] exp_resp;
        int cyc, acc_cyc, addr_cyc, ahs_cyc, sts_cyc, addr_cnt, wbeats, rbeats, bdly;
        bit accepted, addr_seen, addr_done, w_done, b_done, early_w, got_sts, w_hs, r_hs, b_hs, late_sts;
        bad = exp_bad(addr, len);
        exp_resp = 2'b00;
        if (wr) exp_resp = bresp;
        else foreach (rq_resp[i]) if (exp_resp == 2'b00) exp_resp = rq_resp[i];
        if (bad || (r_silent && !wr)) exp_resp = 2'b10;
        cyc = 0; acc_cyc = -1; addr_cyc = -1; ahs_cyc = -1; sts_cyc = -1;
        addr_cnt = 0; wbeats = 0; rbeats = 0; bdly = $urandom_range(0, 3);
        accepted = 0; addr_seen = 0; addr_done = 0; w_done = 0; b_done = 0; early_w = 0;
        got_sts = 0; w_hs = 0; r_hs = 0; b_hs = 0;
        while (!got_sts && cyc < 400) begin
            @(negedge clk);
            cmd_valid = !accepted; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
            if (w_hs) begin wq_data.delete(0); wq_strb.delete(0); wdat_valid = 1'b0; end
            if (wr && !wdat_valid && wq_data.size() > 0 && $urandom_range(0, 3) != 0) begin
                wdat_valid = 1'b1; wdat_data = wq_data[0]; wdat_strb = wq_strb[0];
            end
            w_ready    = ($urandom_range(0, 3) != 0);
            rdat_ready = ($urandom_range(0, 3) != 0);
            ar_ready   = (addr_cnt >= ar_dly);
            aw_ready   = (addr_cnt >= ar_dly);
            if (r_hs) begin rq_data.delete(0); rq_resp.delete(0); r_valid = 1'b0; end
            if (!wr && addr_done && !r_silent && !r_valid && rq_data.size() > 0
                && $urandom_range(0, 3) != 0) begin
                r_valid = 1'b1; r_data = rq_data[0]; r_resp = rq_resp[0]; r_last = (rq_data.size() == 1);
            end
            if (b_hs) begin b_valid = 1'b0; b_done = 1; end
            if (wr && w_done && !b_done && !b_valid) begin
                if (bdly == 0) begin b_valid = 1'b1; b_resp = bresp; end
                else bdly--;
            end
            #1;
            w_hs = wdat_valid && wdat_ready;
            r_hs = r_valid && r_ready;
            b_hs = b_valid && b_ready;
            if (cmd_valid && cmd_ready) begin accepted = 1; acc_cyc = cyc; end
            if ((ar_valid || aw_valid) && !addr_seen) begin
                addr_seen = 1; addr_cyc = cyc;
                if (wr) chk("aw_fields", {aw_addr, aw_len, 5'(aw_size), 2'(aw_burst), 1'(ar_valid)},
                            {addr, 8'(len), 5'd2, 2'b01, 1'b0});
                else    chk("ar_fields", {ar_addr, ar_len, 5'(ar_size), 2'(ar_burst), 1'(aw_valid)},
                            {addr, 8'(len), 5'd2, 2'b01, 1'b0});
            end
            if (ar_valid || aw_valid) addr_cnt++;
            if (w_valid && !addr_done) early_w = 1;
            if ((ar_valid && ar_ready) || (aw_valid && aw_ready)) begin addr_done = 1; ahs_cyc = cyc; end
            if (w_valid && w_ready) begin
                if (wbeats < ew_data.size())
                    chk("w_beat", {w_data, 28'd0, w_strb}, {ew_data[wbeats], 28'd0, ew_strb[wbeats]});
                chk("w_last", 64'(w_last), 64'(wbeats == len));
                wbeats++;
                if (wbeats == len + 1) w_done = 1;
            end
            if (rdat_valid && rdat_ready) begin
                if (rq_data.size() > 0)
                    chk("r_beat", {rdat_data, 30'd0, rdat_resp}, {rq_data[0], 30'd0, rq_resp[0]});
                chk("r_last", 64'(rdat_last), 64'(rbeats == len));
                rbeats++;
            end
            if (sts_valid) begin got_sts = 1; sts_cyc = cyc; end
            cyc++;
            if (abort_at > 0 && wbeats == abort_at) break;
        end

        if (abort_at > 0) begin
            chk("abort_reached", 64'(wbeats), 64'(abort_at));
            @(negedge clk);
            rst = 1'b1; cmd_valid = 1'b0; wdat_valid = 1'b1; w_ready = 1'b1; rdat_ready = 1'b1;
            r_valid = 1'b1; b_valid = 1'b1;
            @(negedge clk); #1;
            chk_quiet("midrst", 1'b0);
            @(negedge clk);
            rst = 1'b0; #1;
            chk_quiet("postrst", 1'b1);
            drive_idle();
            late_sts = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk); #1;
                if (sts_valid) late_sts = 1;
            end
            chk("postrst_no_sts", 64'(late_sts), 64'd0);
            return;
        end

        chk("sts_seen", 64'(got_sts), 64'd1);
        chk("sts_fields", 64'({sts_resp, sts_timeout, sts_badcmd}),
            64'({exp_resp, (r_silent && !wr && !bad), bad}));
        chk("addr_traffic", 64'(addr_seen), 64'(!bad));
        if (bad) chk("bad_latency", 64'(sts_cyc - acc_cyc), 64'd2);
        else     chk("addr_latency", 64'(addr_cyc - acc_cyc), 64'd2);
        if (!bad && wr) chk("w_count_early", 64'({wbeats, 31'(early_w)}), 64'({len + 1, 31'd0}));
        if (!bad && !wr && !r_silent) chk("r_count", 64'(rbeats), 64'(len + 1));
        if (!bad && r_silent) chk("timeout_latency", 64'(sts_cyc - ahs_cyc), 64'(TO + 1));

        @(negedge clk);
        drive_idle();
        #1;
        chk("after_done", 64'({sts_valid, cmd_ready, sts_resp, sts_timeout, sts_badcmd}),
            64'({1'b0, 1'b1, exp_resp, (r_silent && !wr && !bad), bad}));
    endtask

    logic [31:0] ra;
    int          rl;
    logic        rwr;
    logic [1:0]  rb;

    initial begin
        rst = 1'b1;
        drive_idle();
        wdat_valid = 1'b1; w_ready = 1'b1; r_valid = 1'b1; b_valid = 1'b1; rdat_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset", 1'b0);
        chk("tie_zero", 64'({aw_prot, aw_region, aw_lock, aw_cache, aw_qos, aw_id, aw_user,
                             ar_prot, ar_region, ar_lock, ar_cache, ar_qos, ar_id, ar_user, w_user}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);

        gen_beats(3, 1);
        run_cmd(1'b0, 32'h100, 3, 2, 0, 2'b00, 0);

        gen_beats(0, 1);
        wq_data[0] = 32'hA5A5_A5A5; ew_data[0] = 32'hA5A5_A5A5;
        wq_strb[0] = 4'hF;          ew_strb[0] = 4'hF;
        run_cmd(1'b1, 32'h40, 0, 0, 0, 2'b00, 0);

        gen_beats(7, 1);
        run_cmd(1'b1, 32'h200, 7, 1, 0, 2'b10, 0);

        gen_beats(3, 1);
        run_cmd(1'b0, 32'hFF8, 3, 0, 0, 2'b00, 0);
        gen_beats(0, 1);
        run_cmd(1'b1, 32'h102, 0, 0, 0, 2'b00, 0);
        gen_beats(ML, 1);
        run_cmd(1'b0, 32'h0, ML, 0, 0, 2'b00, 0);

        gen_beats(ML - 1, 1);
        run_cmd(1'b1, 32'hFC0, ML - 1, 0, 0, 2'b00, 0);

        gen_beats(1, 1);
        run_cmd(1'b0, 32'h300, 1, 0, 1, 2'b00, 0);

        gen_beats(3, 1);
        run_cmd(1'b1, 32'h400, 3, 0, 0, 2'b00, 2);

        for (int k = 0; k < 30; k++) begin
            rl  = $urandom_range(0, 17);
            ra  = $urandom & 32'h000F_FFFC;
            case ($urandom_range(0, 5))
                0: ra[1:0] = 2'($urandom_range(1, 3));
                1: ra[11:0] = 12'hFF0;
                default: ;
            endcase
            rwr = 1'($urandom_range(0, 1));
            rb  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            gen_beats(rl, 0);
            run_cmd(rwr, ra, rl, $urandom_range(0, 3), 0, rb, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
